// File: rtl/game_pkg.sv
// Shared definitions for the jump-game sequencer: FSM states, screen size,
// default playfield geometry and the block spawn position helper.
package game_pkg;

  localparam int SCREEN_W = 640;

  localparam int X0_DEF          = 80;
  localparam int Y_GROUND_DEF    = 300;
  localparam int BLOCK_W_DEF     = 64;
  localparam int X_STEP_DEF      = 8;
  localparam int Y_STEP_DEF      = 6;
  localparam int MAX_POWER_DEF   = 40;
  localparam int SCROLL_STEP_DEF = 4;
  localparam int GAP_MIN_DEF     = 96;
  localparam int GAP_UNIT_DEF    = 16;

  typedef enum logic [2:0] {
    ST_TITLE,
    ST_WAIT,
    ST_CHARGE,
    ST_JUMP,
    ST_LAND,
    ST_SCROLL,
    ST_GAMEOVER
  } game_state_e;

  // Left x of a freshly spawned target block for a given random value.
  function automatic logic [9:0] spawn_x(input logic [9:0] x0,
                                         input logic [9:0] gap_min,
                                         input logic [9:0] gap_unit,
                                         input logic [3:0] r);
    return x0 + gap_min + gap_unit * {6'd0, r};
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for the (already debounced) jump button.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  logic btn_prev;

  // Remember the button level from the previous clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_prev <= 1'b0;
    else      btn_prev <= i_btn;
  end

  assign o_rise = i_btn & ~btn_prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// Frame-synchronous jump-game sequencer: title/play/gameover flow, charge
// level, man trajectory and block scrolling, feeding the graphics renderer.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int X0          = X0_DEF,
  parameter int Y_GROUND    = Y_GROUND_DEF,
  parameter int BLOCK_W     = BLOCK_W_DEF,
  parameter int X_STEP      = X_STEP_DEF,
  parameter int Y_STEP      = Y_STEP_DEF,
  parameter int MAX_POWER   = MAX_POWER_DEF,
  parameter int SCROLL_STEP = SCROLL_STEP_DEF,
  parameter int GAP_MIN     = GAP_MIN_DEF,
  parameter int GAP_UNIT    = GAP_UNIT_DEF
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_btn,
  input  logic        i_frame_tick,
  input  logic [3:0]  i_rand,
  output logic        o_title,
  output logic        o_gameover,
  output logic [3:0]  o_squeeze_man,
  output logic [9:0]  o_x_man,
  output logic [9:0]  o_y_man,
  output logic [9:0]  o_x_block1,
  output logic        o_en_block1,
  output logic [9:0]  o_x_block2,
  output logic        o_en_block2,
  output logic [3:0]  o_type_block1,
  output logic [3:0]  o_type_block2,
  output logic [15:0] o_score
);

  localparam logic [9:0] X0_L     = 10'(X0);
  localparam logic [9:0] YG_L     = 10'(Y_GROUND);
  localparam logic [9:0] BW_L     = 10'(BLOCK_W);
  localparam logic [9:0] XS_L     = 10'(X_STEP);
  localparam logic [9:0] YS_L     = 10'(Y_STEP);
  localparam logic [5:0] PMAX_L   = 6'(MAX_POWER);
  localparam logic [9:0] SCR_L    = 10'(SCROLL_STEP);
  localparam logic [9:0] GMIN_L   = 10'(GAP_MIN);
  localparam logic [9:0] GUNIT_L  = 10'(GAP_UNIT);
  localparam logic [9:0] X_MAX    = 10'(SCREEN_W - 1);

  game_state_e state_q, state_d;
  logic [5:0]  power_q, power_d, jf_q, jf_d;
  logic [3:0]  squeeze_q, squeeze_d, type1_q, type1_d, type2_q, type2_d;
  logic [9:0]  x_man_q, x_man_d, y_man_q, y_man_d;
  logic [9:0]  x_b1_q, x_b1_d, x_b2_q, x_b2_d;
  logic        en1_q, en1_d, en2_q, en2_d;
  logic [15:0] score_q, score_d;
  logic [9:0]  gap, shift;
  logic [5:0]  half_dn, half_up;
  logic        rise;

  btn_edge u_btn_edge (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (i_btn),
    .o_rise (rise)
  );

  // Next-state and datapath update; scene registers move only on frame ticks.
  always_comb begin
    state_d   = state_q;
    power_d   = power_q;
    jf_d      = jf_q;
    squeeze_d = squeeze_q;
    x_man_d   = x_man_q;
    y_man_d   = y_man_q;
    x_b1_d    = x_b1_q;
    x_b2_d    = x_b2_q;
    en1_d     = en1_q;
    en2_d     = en2_q;
    type1_d   = type1_q;
    type2_d   = type2_q;
    score_d   = score_q;
    gap       = x_b2_q - X0_L;
    shift     = (gap < SCR_L) ? gap : SCR_L;
    half_dn   = power_q >> 1;
    half_up   = 6'((power_q + 6'd1) >> 1);
    unique case (state_q)
      ST_TITLE: begin
        if (rise) begin
          score_d = '0;
          x_b1_d  = X0_L;
          type1_d = '0;
          en1_d   = 1'b1;
          en2_d   = 1'b1;
          x_b2_d  = spawn_x(X0_L, GMIN_L, GUNIT_L, i_rand);
          type2_d = i_rand;
          x_man_d = X0_L + (BW_L >> 1);
          y_man_d = YG_L;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rise) begin
          power_d   = 6'd1;
          squeeze_d = '0;
          state_d   = ST_CHARGE;
        end
      end
      ST_CHARGE: begin
        if (!i_btn) begin
          squeeze_d = '0;
          jf_d      = '0;
          state_d   = ST_JUMP;
        end else if (i_frame_tick) begin
          power_d   = (power_q >= PMAX_L) ? PMAX_L : power_q + 6'd1;
          squeeze_d = (squeeze_q == 4'hF) ? 4'hF : squeeze_q + 4'd1;
        end
      end
      ST_JUMP: begin
        if (i_frame_tick) begin
          jf_d    = jf_q + 6'd1;
          x_man_d = (x_man_q > X_MAX - XS_L) ? X_MAX : x_man_q + XS_L;
          // Rise for the first floor(p/2) frames, fall from ceil(p/2) on.
          if (jf_q < half_dn)       y_man_d = y_man_q - YS_L;
          else if (jf_q >= half_up) y_man_d = y_man_q + YS_L;
          if (jf_d == power_q) state_d = ST_LAND;
        end
      end
      ST_LAND: begin
        if (x_man_q >= x_b2_q && x_man_q <= x_b2_q + BW_L - 10'd1) begin
          score_d = score_q + 16'd1;
          state_d = ST_SCROLL;
        end else begin
          state_d = ST_GAMEOVER;
        end
      end
      ST_SCROLL: begin
        if (i_frame_tick) begin
          x_b2_d  = x_b2_q - shift;
          x_man_d = x_man_q - shift;
          if (x_b1_q >= shift) x_b1_d = x_b1_q - shift;
          else                 en1_d  = 1'b0;
          // Target block has arrived at the rest position: it becomes the
          // current block and a new target is spawned.
          if (x_b2_d == X0_L) begin
            x_b1_d  = x_b2_d;
            type1_d = type2_q;
            en1_d   = 1'b1;
            x_b2_d  = spawn_x(X0_L, GMIN_L, GUNIT_L, i_rand);
            type2_d = i_rand;
            state_d = ST_WAIT;
          end
        end
      end
      ST_GAMEOVER: begin
        if (rise) begin
          en1_d   = 1'b0;
          en2_d   = 1'b0;
          state_d = ST_TITLE;
        end
      end
      default: state_d = ST_TITLE;
    endcase
  end

  // State and datapath registers; reset puts the renderer on the title screen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_TITLE;
      power_q   <= '0;
      jf_q      <= '0;
      squeeze_q <= '0;
      x_man_q   <= '0;
      y_man_q   <= '0;
      x_b1_q    <= '0;
      x_b2_q    <= '0;
      en1_q     <= 1'b0;
      en2_q     <= 1'b0;
      type1_q   <= '0;
      type2_q   <= '0;
      score_q   <= '0;
    end else begin
      state_q   <= state_d;
      power_q   <= power_d;
      jf_q      <= jf_d;
      squeeze_q <= squeeze_d;
      x_man_q   <= x_man_d;
      y_man_q   <= y_man_d;
      x_b1_q    <= x_b1_d;
      x_b2_q    <= x_b2_d;
      en1_q     <= en1_d;
      en2_q     <= en2_d;
      type1_q   <= type1_d;
      type2_q   <= type2_d;
      score_q   <= score_d;
    end
  end

  assign o_title       = (state_q == ST_TITLE);
  assign o_gameover    = (state_q == ST_GAMEOVER);
  assign o_squeeze_man = squeeze_q;
  assign o_x_man       = x_man_q;
  assign o_y_man       = y_man_q;
  assign o_x_block1    = x_b1_q;
  assign o_en_block1   = en1_q;
  assign o_x_block2    = x_b2_q;
  assign o_en_block2   = en2_q;
  assign o_type_block1 = type1_q;
  assign o_type_block2 = type2_q;
  assign o_score       = score_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl with an abstract game model.
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_btn = 1'b0;
  logic        i_frame_tick = 1'b0;
  logic [3:0]  i_rand = 4'd0;
  logic        o_title, o_gameover, o_en_block1, o_en_block2;
  logic [3:0]  o_squeeze_man, o_type_block1, o_type_block2;
  logic [9:0]  o_x_man, o_y_man, o_x_block1, o_x_block2;
  logic [15:0] o_score;

  game_flow_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_btn         (i_btn),
    .i_frame_tick  (i_frame_tick),
    .i_rand        (i_rand),
    .o_title       (o_title),
    .o_gameover    (o_gameover),
    .o_squeeze_man (o_squeeze_man),
    .o_x_man       (o_x_man),
    .o_y_man       (o_y_man),
    .o_x_block1    (o_x_block1),
    .o_en_block1   (o_en_block1),
    .o_x_block2    (o_x_block2),
    .o_en_block2   (o_en_block2),
    .o_type_block1 (o_type_block1),
    .o_type_block2 (o_type_block2),
    .o_score       (o_score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        title;
    logic        gameover;
    logic [3:0]  sq;
    logic [9:0]  xm;
    logic [9:0]  ym;
    logic [9:0]  xb1;
    logic        en1;
    logic [9:0]  xb2;
    logic        en2;
    logic [3:0]  t1;
    logic [3:0]  t2;
    logic [15:0] score;
  } view_t;

  view_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    fix_rand = 1'b1;

  // Game model: phases of play, with charge and flight in closed form.
  typedef enum {P_TITLE, P_READY, P_CHARGE, P_AIR, P_JUDGE, P_SHIFT, P_OVER} phase_t;
  phase_t ph;
  int  held, pw, k, x_start, xm, ym, xb1, xb2, t1, t2, score;
  bit  en1, en2, prevb;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    ph = P_TITLE; held = 0; pw = 0; k = 0; x_start = 0;
    xm = 0; ym = 0; xb1 = 0; xb2 = 0; t1 = 0; t2 = 0; score = 0;
    en1 = 0; en2 = 0; prevb = 0;
  endtask

  task automatic model_step(input bit b, input bit tick, input int r);
    bit rise;
    int d;
    rise  = b && !prevb;
    prevb = b;
    case (ph)
      P_TITLE: if (rise) begin
        score = 0; xb1 = 80; t1 = 0; en1 = 1; en2 = 1;
        xb2 = 176 + 16 * r; t2 = r; xm = 112; ym = 300; ph = P_READY;
      end
      P_READY: if (rise) begin ph = P_CHARGE; held = 0; end
      P_CHARGE: begin
        if (!b) begin
          pw = imin(1 + held, 40); k = 0; x_start = xm; ph = P_AIR;
        end else if (tick) held++;
      end
      P_AIR: if (tick) begin
        k++;
        xm = imin(x_start + 8 * k, 639);
        ym = 300 - 6 * imin(k, pw / 2) + 6 * imax(0, k - (pw + 1) / 2);
        if (k == pw) ph = P_JUDGE;
      end
      P_JUDGE: begin
        if (xm >= xb2 && xm <= xb2 + 63) begin
          score = (score + 1) % 65536; ph = P_SHIFT;
        end else ph = P_OVER;
      end
      P_SHIFT: if (tick) begin
        d = imin(4, xb2 - 80);
        xb2 -= d; xm -= d;
        if (xb1 >= d) xb1 -= d; else en1 = 0;
        if (xb2 == 80) begin
          xb1 = 80; t1 = t2; en1 = 1; xb2 = 176 + 16 * r; t2 = r; ph = P_READY;
        end
      end
      P_OVER: if (rise) begin en1 = 0; en2 = 0; ph = P_TITLE; end
      default: ph = P_TITLE;
    endcase
  endtask

  function automatic view_t model_view();
    view_t v;
    v.title    = (ph == P_TITLE);
    v.gameover = (ph == P_OVER);
    v.sq       = (ph == P_CHARGE) ? 4'(imin(held, 15)) : 4'd0;
    v.xm       = 10'(xm);
    v.ym       = 10'(ym);
    v.xb1      = 10'(xb1);
    v.en1      = en1;
    v.xb2      = 10'(xb2);
    v.en2      = en2;
    v.t1       = 4'(t1);
    v.t2       = 4'(t2);
    v.score    = 16'(score);
    return v;
  endfunction

  function automatic view_t dut_view();
    return {o_title, o_gameover, o_squeeze_man, o_x_man, o_y_man, o_x_block1,
            o_en_block1, o_x_block2, o_en_block2, o_type_block1, o_type_block2, o_score};
  endfunction

  // One clock of stimulus; the expected post-edge view goes to the scoreboard.
  task automatic step(input bit b);
    @(negedge clk);
    i_btn        = b;
    i_frame_tick = (cyc % 4 == 3);
    i_rand       = fix_rand ? 4'd0 : 4'($urandom_range(0, 15));
    cyc++;
    if (!rst) model_reset();
    else      model_step(b, i_frame_tick, int'(i_rand));
    sb.push_back(model_view());
  endtask

  // Hold the button through n frame ticks after the press, then release.
  task automatic press_hold(input int n);
    int ticks;
    ticks = 0;
    step(1'b1);
    while (ticks < n) begin
      step(1'b1);
      if (i_frame_tick) ticks++;
    end
    step(1'b0);
  endtask

  task automatic settle();
    int guard;
    guard = 0;
    while ((ph == P_CHARGE || ph == P_AIR || ph == P_JUDGE || ph == P_SHIFT) && guard < 3000) begin
      step(1'b0);
      guard++;
    end
    n_checks++;
    if (guard >= 3000) begin
      n_fail++;
      $display("FAIL settle_timeout: still busy after %0d cycles, required fewer than 3000", guard);
    end
  endtask

  task automatic restart();
    if (ph == P_OVER) begin step(1'b1); step(1'b0); end
    if (ph == P_TITLE) begin step(1'b1); step(1'b0); end
  endtask

  task automatic async_reset_check();
    view_t a, e;
    @(negedge clk);
    i_btn = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    e = model_view();
    a = dut_view();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL async_reset: actual=%h required=%h", a, e);
    end
  endtask

  // Monitor: compare DUT outputs against queued expectations after each edge.
  always @(posedge clk) begin
    view_t e, a;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = dut_view();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t actual=%h required=%h (title,gov,sq,xm,ym,xb1,en1,xb2,en2,t1,t2,score)",
                 $time, a, e);
      end
    end
  end

  initial begin
    int target, p;
    model_reset();
    rst = 1'b0;
    repeat (3) step(1'b0);
    rst = 1'b1;
    repeat (2) step(1'b0);

    // Deterministic round: land after 11 frames, scroll, respawn at rand 0.
    step(1'b1); step(1'b0);
    press_hold(10);
    settle();
    // Full charge overshoots the target.
    press_hold(50);
    settle();
    restart();
    // Press and release inside one frame: single-frame hop.
    press_hold(0);
    settle();
    restart();

    // Randomised rounds, half aimed at the target block.
    fix_rand = 1'b0;
    for (int g = 0; g < 30; g++) begin
      restart();
      repeat ($urandom_range(0, 5)) step(1'b0);
      if ($urandom_range(0, 1) == 1) begin
        target = xb2 + int'($urandom_range(8, 63));
        p = imax(1, imin(40, (target - xm) / 8));
        press_hold(p - 1);
      end else begin
        press_hold(int'($urandom_range(0, 45)));
      end
      settle();
    end

    // Asynchronous reset in the middle of a jump, then a fresh game.
    restart();
    press_hold(20);
    repeat (10) step(1'b0);
    async_reset_check();
    step(1'b0); step(1'b0);
    rst = 1'b1;
    step(1'b0);
    step(1'b1); step(1'b0);
    press_hold(3);
    settle();

    repeat (3) step(1'b0);
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
